// File: rtl/uart_pkg.sv
// Shared UART datapath definitions: parity mode encodings and the DATA_LEN width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_SPACE = 2'b10,
        PAR_MARK  = 2'b11
    } par_mode_e;

    // Width of a field able to hold a bit count of 0..max_w.
    function automatic int len_w(input int max_w);
        return $clog2(max_w + 1);
    endfunction

endpackage

// File: rtl/parity_core.sv
// Combinational parity kernel: DATA_LEN masking, XOR reduction and mode mapping to the expected bit.
module parity_core
    import uart_pkg::*;
#(
    parameter int DATA_MAX_W = 8
) (
    input  logic [DATA_MAX_W-1:0]          data,
    input  logic [len_w(DATA_MAX_W)-1:0]   len,
    input  logic [1:0]                     mode,
    output logic                           e
);

    localparam int LEN_W = len_w(DATA_MAX_W);

    logic [LEN_W-1:0]      eff_len;
    logic [DATA_MAX_W-1:0] masked;
    logic                  red_xor;

    // Zero or out-of-range lengths fall back to the full word.
    always_comb begin
        eff_len = len;
        if (len == '0 || len > LEN_W'(DATA_MAX_W)) begin
            eff_len = LEN_W'(DATA_MAX_W);
        end
    end

    always_comb begin
        masked = '0;
        for (int i = 0; i < DATA_MAX_W; i++) begin
            masked[i] = (LEN_W'(i) < eff_len) ? data[i] : 1'b0;
        end
    end

    assign red_xor = ^masked;

    always_comb begin
        e = 1'b0;
        case (mode)
            PAR_EVEN:  e = red_xor;
            PAR_ODD:   e = ~red_xor;
            PAR_SPACE: e = 1'b0;
            PAR_MARK:  e = 1'b1;
            default:   e = 1'b0;
        endcase
    end

endmodule

// File: rtl/parity_unit.sv
// UART parity generator/checker with sticky error flag; the saturating error
// counter is built only when PARITY_ERR_CNT_EN is defined.
module parity_unit
    import uart_pkg::*;
#(
    parameter int DATA_MAX_W = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_MAX_W-1:0]         P_DATA,
    input  logic [len_w(DATA_MAX_W)-1:0]  DATA_LEN,
    input  logic                          PAR_EN,
    input  logic [1:0]                    PAR_MODE,
    input  logic                          GEN_VLD,
    input  logic                          CHK_VLD,
    input  logic                          RX_PAR_BIT,
    input  logic                          ERR_CLR,
    output logic                          par_bit,
    output logic                          gen_done,
    output logic                          chk_done,
    output logic                          par_err,
    output logic                          err_sticky,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    logic exp_bit_p0;
    logic mismatch_p0;

    logic par_bit_p1;
    logic gen_vld_p1;
    logic chk_vld_p1;
    logic par_err_p1;
    logic sticky_p1;

    // One shared kernel serves both generate and check requests.
    parity_core #(
        .DATA_MAX_W (DATA_MAX_W)
    ) u_core (
        .data (P_DATA),
        .len  (DATA_LEN),
        .mode (PAR_MODE),
        .e    (exp_bit_p0)
    );

    assign mismatch_p0 = CHK_VLD & PAR_EN & (RX_PAR_BIT != exp_bit_p0);

    // ---- stage p0 -> p1: request sampling ----
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_bit_p1 <= 1'b0;
            gen_vld_p1 <= 1'b0;
            chk_vld_p1 <= 1'b0;
            par_err_p1 <= 1'b0;
            sticky_p1  <= 1'b0;
        end else begin
            gen_vld_p1 <= GEN_VLD;
            chk_vld_p1 <= CHK_VLD;
            par_err_p1 <= mismatch_p0;
            if (GEN_VLD) begin
                par_bit_p1 <= PAR_EN & exp_bit_p0;
            end
            if (mismatch_p0) begin
                sticky_p1 <= 1'b1;
            end else if (ERR_CLR) begin
                sticky_p1 <= 1'b0;
            end
        end
    end

`ifdef PARITY_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    logic [ERR_CNT_W-1:0] err_cnt_p1;

    // A clear coinciding with an error restarts the count at one.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt_p1 <= '0;
        end else if (mismatch_p0) begin
            if (ERR_CLR) begin
                err_cnt_p1 <= ERR_CNT_W'(1);
            end else if (err_cnt_p1 != CNT_MAX) begin
                err_cnt_p1 <= err_cnt_p1 + ERR_CNT_W'(1);
            end
        end else if (ERR_CLR) begin
            err_cnt_p1 <= '0;
        end
    end

    assign err_cnt = err_cnt_p1;
`else
    assign err_cnt = '0;
`endif

    assign par_bit    = par_bit_p1;
    assign gen_done   = gen_vld_p1;
    assign chk_done   = chk_vld_p1;
    assign par_err    = par_err_p1;
    assign err_sticky = sticky_p1;

endmodule

// File: doc/parity_unit.md
# parity_unit

Parametrised parity generator/checker for the UART datapath, successor to the fixed 8-bit even/odd parity calculator. It computes the parity bit for the TX serializer and checks the received parity for the RX deserializer, using the same data word and configuration. It supports a runtime frame length (1..DATA_MAX_W bits), four parity modes and a global enable. It reports errors as a per-frame pulse, a sticky flag and an optional saturating error counter, and sits between the UART register file and the TX/RX frame FSMs.

## Interface
- DATA_MAX_W, 8, maximum data bits per frame (≥2)
- ERR_CNT_W, 8, width of parity-error counter
- CLK  in  1  system/UART clock, rising edge
- RST  in  1  asynchronous, active-low reset
- P_DATA  in  DATA_MAX_W  data word, LSB = first bit on line
- DATA_LEN  in  $clog2(DATA_MAX_W+1)  number of valid data bits, LSB-aligned
- PAR_EN  in  1  parity enable
- PAR_MODE  in  2  00 even, 01 odd, 10 space (always 0), 11 mark (always 1)
- GEN_VLD  in  1  one-cycle request: generate parity for P_DATA
- CHK_VLD  in  1  one-cycle request: check RX_PAR_BIT against P_DATA
- RX_PAR_BIT  in  1  received parity bit
- ERR_CLR  in  1  clears err_sticky and err_cnt
- par_bit  out  1  generated parity, registered
- gen_done  out  1  one-cycle pulse, par_bit updated
- chk_done  out  1  one-cycle pulse, par_err valid
- par_err  out  1  registered, high for exactly one cycle with chk_done on mismatch
- err_sticky  out  1  set on any parity error until ERR_CLR
- err_cnt  out  ERR_CNT_W  saturating error count (PARITY_ERR_CNT_EN only)

## Operation
- Masking: bits at index ≥ DATA_LEN are forced to 0 before the XOR reduction. DATA_LEN = 0 or > DATA_MAX_W is treated as DATA_MAX_W.
- Expected bit e: even = ^masked, odd = ~^masked, space = 0, mark = 1. With even parity, the total count of ones including the parity bit is even.
- Inputs are sampled only in a cycle where GEN_VLD or CHK_VLD is high. Changes to P_DATA, DATA_LEN, PAR_MODE or PAR_EN between requests have no effect.
- GEN_VLD: par_bit ← e when PAR_EN = 1, else 0. gen_done pulses in both cases. par_bit holds its value between requests.
- CHK_VLD: mismatch = PAR_EN & (RX_PAR_BIT ≠ e). par_err ← mismatch and chk_done pulses. With PAR_EN = 0, checks never flag an error.
- GEN_VLD and CHK_VLD together: both are served from the same sampled word, independently, and both done pulses fire.
- Error bookkeeping: a mismatch sets err_sticky and increments err_cnt, which saturates at 2^ERR_CNT_W−1 with no wrap.
- ERR_CLR in the same cycle as a mismatch: the error wins. err_sticky = 1 and err_cnt = 1.
- Datapath state: IDLE/BUSY is not needed. Each request completes in one cycle and back-to-back requests are accepted every cycle.

## Timing
- Latency: request in cycle N → par_bit/par_err/done pulses valid in cycle N+1.
- Pulses (gen_done, chk_done, par_err) are high for exactly one cycle per request.
- ERR_CLR takes effect at the next edge.
- Reset: par_bit = 0, gen_done = 0, chk_done = 0, par_err = 0, err_sticky = 0, err_cnt = 0.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). A request pending in the same cycle is dropped.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- PARITY_ERR_CNT_EN defined: err_cnt register and saturating incrementer are built as specified.
- PARITY_ERR_CNT_EN undefined: no counter flops. err_cnt is tied to 0 and err_sticky behaves identically.

## Structure
- Shared uart_pkg holds the PAR_MODE encodings (PAR_EVEN=2'b00, PAR_ODD=2'b01, PAR_SPACE=2'b10, PAR_MARK=2'b11) and the DATA_LEN width function.
- One combinational sub-module, parity_core, performs DATA_LEN masking, the XOR reduction and the mode mapping to e. It is instantiated once and shared by the generate and check paths.
- Top level holds the registers, pulse generation and the error sticky/counter.

## Test plan
- Reset, then GEN_VLD with P_DATA=8'hA5, DATA_LEN=8, even → next cycle par_bit=0, gen_done=1 for one cycle. Repeat with odd → par_bit=1.
- P_DATA=8'hFF, DATA_LEN=7, even → par_bit=1 (bit 7 masked). Repeat with DATA_LEN=0 → treated as 8, par_bit=0.
- Mark then space with P_DATA=8'h00 → par_bit=1 then 0. With PAR_EN=0, CHK_VLD and RX_PAR_BIT=1 → chk_done=1, par_err=0.
- CHK_VLD with P_DATA=8'h01, even, RX_PAR_BIT=0 → par_err=1 pulse, err_sticky=1, err_cnt=1. 300 further errors with ERR_CNT_W=8 → err_cnt holds 255.
- ERR_CLR coincident with a mismatch → err_sticky=1, err_cnt=1. ERR_CLR alone on the next cycle → both 0.
- GEN_VLD and CHK_VLD together, then back-to-back for 4 cycles, then RST low mid-stream → both done pulses fire each cycle. All outputs go 0 asynchronously on reset.
